// File: rtl/tx_gate_pkg.sv
// Shared definitions for the single-clock TX channel gate: FSM states, entry tags,
// header field placement and the close-marker flag position.
package tx_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSED  = 2'd3
    } gate_state_t;

    localparam logic TAG_CTRL = 1'b1;
    localparam logic TAG_DATA = 1'b0;

    localparam int HDR_LAST_BIT = 0;
    localparam int HDR_OFF_LSB  = 1;
    localparam int HDR_OFF_W    = 31;
    localparam int HDR_LEN_LSB  = 32;
    localparam int HDR_LEN_W    = 32;

    localparam int WORD_CNT_W = 32;

    // Close markers set the top payload bit so they never look like a header.
    function automatic int marker_flag_bit(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/tx_port_channel_gate_sc_if.sv
// Channel-side and reader-side signals of the TX channel gate; the gate is the slave,
// the user channel plus tx_port reader together form the master.
interface tx_port_channel_gate_sc_if #(
    parameter int C_DATA_WIDTH = 256
);
    logic                    chnl_tx;
    logic                    chnl_tx_ack;
    logic                    chnl_tx_last;
    logic [31:0]             chnl_tx_len;
    logic [30:0]             chnl_tx_off;
    logic [C_DATA_WIDTH-1:0] chnl_tx_data;
    logic                    chnl_tx_data_valid;
    logic                    chnl_tx_data_ren;
    logic [C_DATA_WIDTH:0]   rd_data;
    logic                    rd_empty;
    logic                    rd_en;

    modport master (
        output chnl_tx, chnl_tx_last, chnl_tx_len, chnl_tx_off,
        output chnl_tx_data, chnl_tx_data_valid, rd_en,
        input  chnl_tx_ack, chnl_tx_data_ren, rd_data, rd_empty
    );

    modport slave (
        input  chnl_tx, chnl_tx_last, chnl_tx_len, chnl_tx_off,
        input  chnl_tx_data, chnl_tx_data_valid, rd_en,
        output chnl_tx_ack, chnl_tx_data_ren, rd_data, rd_empty
    );
endinterface

// File: rtl/tx_gate_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and almost-full flag
// (count >= DEPTH-1). Reads of an empty FIFO are ignored.
module tx_gate_sync_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             af
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_rd;

    assign do_rd = rd_en && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !do_rd) begin
                count_reg <= count_reg + CW'(1);
            end else if (!wr_en && do_rd) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign af      = (count_reg >= CW'(DEPTH - 1));

endmodule

// File: rtl/tx_port_channel_gate_sc.sv
// TX channel gate: queues tagged open headers, channel data and close markers for the
// tx_port reader. Define TXGATE_WORD_COUNT_EN to carry the accepted-word count in markers.
module tx_port_channel_gate_sc
    import tx_gate_pkg::*;
#(
    parameter int C_DATA_WIDTH = 256,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    tx_port_channel_gate_sc_if.slave bus
);

    localparam int C_FIFO_WIDTH    = C_DATA_WIDTH + 1;
    localparam int CNT_W           = $clog2(C_FIFO_DEPTH + 1);
    localparam int MARKER_FLAG_BIT = marker_flag_bit(C_DATA_WIDTH);

    gate_state_t             state_reg;
    logic                    r_chnl_tx_reg;
    logic                    r_chnl_last_reg;
    logic [31:0]             r_chnl_len_reg;
    logic [30:0]             r_chnl_off_reg;
    logic                    ack_reg;
    logic                    open_reg;
    logic                    marker_cnt_reg;
    logic                    wr_en_reg;
    logic [C_FIFO_WIDTH-1:0] wr_data_reg;

    logic [C_FIFO_WIDTH-1:0] header;
    logic [C_FIFO_WIDTH-1:0] marker;
    logic [WORD_CNT_W-1:0]   word_count;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_af;
    logic                    ren;
    logic                    accept;

    tx_gate_sync_fifo #(
        .WIDTH (C_FIFO_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_reg),
        .wr_data (wr_data_reg),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .count   (fifo_count),
        .af      (fifo_af)
    );

    assign ren                  = open_reg && !fifo_af;
    assign accept               = ren && bus.chnl_tx_data_valid;
    assign bus.chnl_tx_data_ren = ren;
    assign bus.chnl_tx_ack      = ack_reg;
    assign bus.rd_empty         = (fifo_count == '0);

    always_comb begin
        header                                 = '0;
        header[C_FIFO_WIDTH-1]                 = TAG_CTRL;
        header[HDR_LAST_BIT]                   = r_chnl_last_reg;
        header[HDR_OFF_LSB +: HDR_OFF_W]       = r_chnl_off_reg;
        header[HDR_LEN_LSB +: HDR_LEN_W]       = r_chnl_len_reg;
        marker                                 = '0;
        marker[C_FIFO_WIDTH-1]                 = TAG_CTRL;
        marker[MARKER_FLAG_BIT]                = 1'b1;
        marker[WORD_CNT_W-1:0]                 = word_count;
    end

`ifdef TXGATE_WORD_COUNT_EN
    localparam logic [WORD_CNT_W:0] BEAT_WORDS = (WORD_CNT_W + 1)'(C_DATA_WIDTH / 32);

    logic [WORD_CNT_W-1:0] word_cnt_reg;
    logic [WORD_CNT_W:0]   word_sum;

    assign word_sum = {1'b0, word_cnt_reg} + BEAT_WORDS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            word_cnt_reg <= '0;
        end else if (accept) begin
            word_cnt_reg <= word_sum[WORD_CNT_W] ? '1 : word_sum[WORD_CNT_W-1:0];
        end
    end

    assign word_count = word_cnt_reg;
`else
    assign word_count = '0;
`endif

    // Every write is registered one cycle and only issued while not almost-full,
    // which leaves exactly one slot for the write already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            r_chnl_tx_reg   <= 1'b0;
            r_chnl_last_reg <= 1'b0;
            r_chnl_len_reg  <= '0;
            r_chnl_off_reg  <= '0;
            ack_reg         <= 1'b0;
            open_reg        <= 1'b0;
            marker_cnt_reg  <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_data_reg     <= '0;
        end else begin
            r_chnl_tx_reg   <= bus.chnl_tx;
            r_chnl_last_reg <= bus.chnl_tx_last;
            r_chnl_len_reg  <= bus.chnl_tx_len;
            r_chnl_off_reg  <= bus.chnl_tx_off;
            ack_reg         <= 1'b0;
            wr_en_reg       <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (r_chnl_tx_reg && !fifo_af) begin
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= header;
                        ack_reg     <= 1'b1;
                        state_reg   <= ST_OPENING;
                    end
                end
                ST_OPENING: begin
                    if (!r_chnl_tx_reg) begin
                        state_reg <= ST_CLOSED;
                    end else if (!fifo_af) begin
                        open_reg  <= bus.chnl_tx && r_chnl_tx_reg;
                        state_reg <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    open_reg <= bus.chnl_tx && r_chnl_tx_reg;
                    if (accept) begin
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= {TAG_DATA, bus.chnl_tx_data};
                    end
                    if (!r_chnl_tx_reg) begin
                        state_reg <= ST_CLOSED;
                    end
                end
                ST_CLOSED: begin
                    if (!fifo_af) begin
                        wr_en_reg      <= 1'b1;
                        wr_data_reg    <= marker;
                        marker_cnt_reg <= !marker_cnt_reg;
                        if (marker_cnt_reg) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
